// File: rtl/regfile_sb.sv
// Register file with write-through bypass, PC-relative top register and a
// per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_sb #(
    parameter  int WIDTH = 32,
    parameter  int NREGS = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] reg1_data,
    output logic [WIDTH-1:0] reg2_data,
    input  logic [WIDTH-1:0] pc,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             iss_valid,
    input  logic             iss_use1,
    input  logic             iss_use2,
    input  logic             iss_wr,
    input  logic [AW-1:0]    iss_dst,
    input  logic             flush,
    output logic             stall,
    output logic [NREGS-1:0] busy_vec
);

    localparam logic [AW-1:0] PC_ADDR = AW'(NREGS - 1);

    logic [WIDTH-1:0] rf_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] eb_s;
    logic [WIDTH-1:0] pc_plus8_s;
    logic             stall_s;
    logic             issue_ok_s;

    assign pc_plus8_s = pc + WIDTH'(8);

    // Read port 1: PC register, then same-cycle writeback bypass, then storage
    always_comb begin
        if (rd_addr1 == PC_ADDR) begin
            reg1_data = pc_plus8_s;
        end else if (we && (wr_addr == rd_addr1)) begin
            reg1_data = wr_data;
        end else begin
            reg1_data = rf_q[rd_addr1];
        end
    end

    // Read port 2: same selection as port 1
    always_comb begin
        if (rd_addr2 == PC_ADDR) begin
            reg2_data = pc_plus8_s;
        end else if (we && (wr_addr == rd_addr2)) begin
            reg2_data = wr_data;
        end else begin
            reg2_data = rf_q[rd_addr2];
        end
    end

    // Effective busy: a register being written back this cycle counts as ready
    always_comb begin
        eb_s = '0;
        for (int i = 0; i < NREGS; i++) begin
            eb_s[i] = busy_q[i] && !(we && (wr_addr == AW'(i)));
        end
    end

    // Hazard detection and issue acceptance
    always_comb begin
        stall_s    = iss_valid && ((iss_use1 && eb_s[rd_addr1]) ||
                                   (iss_use2 && eb_s[rd_addr2]) ||
                                   (iss_wr   && eb_s[iss_dst]));
        issue_ok_s = iss_valid && !stall_s;
    end

    // Busy next state: flush clears all; otherwise clear on writeback, then set wins
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (we) begin
                busy_d[wr_addr] = 1'b0;
            end else begin
                busy_d = busy_q;
            end
            if (issue_ok_s && iss_wr && (iss_dst != PC_ADDR)) begin
                busy_d[iss_dst] = 1'b1;
            end else begin
                busy_d[PC_ADDR] = 1'b0;
            end
        end
        busy_d[PC_ADDR] = 1'b0;
    end

    // Scoreboard state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Register storage; flush deliberately leaves contents untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we) begin
            rf_q[wr_addr] <= wr_data;
        end
    end

    assign stall    = stall_s;
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expected values are queued as stimulus is
// applied and popped against the DUT outputs once they have settled.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rd_addr1, rd_addr2;
    logic [31:0] reg1_data, reg2_data;
    logic [31:0] pc;
    logic        we;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_valid, iss_use1, iss_use2, iss_wr;
    logic [3:0]  iss_dst;
    logic        flush;
    logic        stall;
    logic [15:0] busy_vec;

    int errors = 0;
    int checks = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    regfile_sb #(.WIDTH(32), .NREGS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .reg1_data(reg1_data), .reg2_data(reg2_data),
        .pc(pc), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_use1(iss_use1), .iss_use2(iss_use2),
        .iss_wr(iss_wr), .iss_dst(iss_dst), .flush(flush),
        .stall(stall), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic observe(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h with nothing expected", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rd_addr1 = 4'd0; rd_addr2 = 4'd0; pc = 32'h100;
        we = 1'b0; wr_addr = 4'd0; wr_data = 32'h0;
        iss_valid = 1'b0; iss_use1 = 1'b0; iss_use2 = 1'b0; iss_wr = 1'b0;
        iss_dst = 4'd0; flush = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // reset contents: r0..r14 zero, r15 = pc + 8
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rd_addr1 = 4'(i); rd_addr2 = 4'(15 - i);
            expect_val("rst_rd1", (i == 15) ? 32'h108 : 32'h0);
            expect_val("rst_rd2", (i == 0) ? 32'h108 : 32'h0);
            #1;
            observe(reg1_data);
            observe(reg2_data);
        end
        expect_val("rst_busy", 32'h0); expect_val("rst_stall", 32'h0);
        observe({16'h0, busy_vec}); observe({31'h0, stall});

        // basic writes on consecutive edges
        tick();
        we = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
        tick();
        wr_addr = 4'd7; wr_data = 32'h12345678;
        tick();
        we = 1'b0; rd_addr1 = 4'd3; rd_addr2 = 4'd7;
        expect_val("wr_r3", 32'hDEADBEEF); expect_val("wr_r7", 32'h12345678);
        #1; observe(reg1_data); observe(reg2_data);

        // same-cycle bypass on both ports
        we = 1'b1; wr_addr = 4'd5; wr_data = 32'hA5A5A5A5; rd_addr1 = 4'd5; rd_addr2 = 4'd5;
        expect_val("bypass1", 32'hA5A5A5A5); expect_val("bypass2", 32'hA5A5A5A5);
        #1; observe(reg1_data); observe(reg2_data);
        tick();
        we = 1'b0;
        expect_val("stored_r5", 32'hA5A5A5A5);
        #1; observe(reg1_data);

        // PC register ignores both bypass and stored data
        pc = 32'h2000; we = 1'b1; wr_addr = 4'd15; wr_data = 32'hFFFF; rd_addr1 = 4'd15;
        expect_val("pc_bypass", 32'h2008);
        #1; observe(reg1_data);
        tick();
        we = 1'b0;
        iss_valid = 1'b1; iss_wr = 1'b1; iss_dst = 4'd15;
        expect_val("pc_after_wr", 32'h2008); expect_val("pc_issue_stall", 32'h0);
        #1; observe(reg1_data); observe({31'h0, stall});
        tick();
        iss_valid = 1'b0; iss_wr = 1'b0;
        expect_val("pc_busy", 32'h0);
        #1; observe({16'h0, busy_vec});

        // RAW on r4
        iss_valid = 1'b1; iss_wr = 1'b1; iss_dst = 4'd4;
        expect_val("raw_first_stall", 32'h0);
        #1; observe({31'h0, stall});
        tick();
        iss_wr = 1'b0; iss_use1 = 1'b1; rd_addr1 = 4'd4;
        expect_val("raw_busy", 32'h0010); expect_val("raw_stall_c1", 32'h1);
        #1; observe({16'h0, busy_vec}); observe({31'h0, stall});
        tick();
        expect_val("raw_stall_c2", 32'h1);
        #1; observe({31'h0, stall});
        tick();
        we = 1'b1; wr_addr = 4'd4; wr_data = 32'h55;
        expect_val("raw_wb_stall", 32'h0); expect_val("raw_wb_data", 32'h55);
        #1; observe({31'h0, stall}); observe(reg1_data);
        tick();
        we = 1'b0; iss_valid = 1'b0; iss_use1 = 1'b0;
        expect_val("raw_busy_clear", 32'h0);
        #1; observe({16'h0, busy_vec});

        // WAW on r2 and simultaneous set/clear
        iss_valid = 1'b1; iss_wr = 1'b1; iss_dst = 4'd2;
        tick();
        expect_val("waw_busy", 32'h0004); expect_val("waw_stall", 32'h1);
        #1; observe({16'h0, busy_vec}); observe({31'h0, stall});
        tick();
        expect_val("waw_held_busy", 32'h0004);
        #1; observe({16'h0, busy_vec});
        we = 1'b1; wr_addr = 4'd2; wr_data = 32'h22;
        expect_val("waw_wb_stall", 32'h0);
        #1; observe({31'h0, stall});
        tick();
        we = 1'b0; iss_valid = 1'b0; iss_wr = 1'b0; rd_addr2 = 4'd2;
        expect_val("setclr_busy", 32'h0004); expect_val("waw_data", 32'h22);
        #1; observe({16'h0, busy_vec}); observe(reg2_data);
        we = 1'b1; wr_addr = 4'd2; wr_data = 32'h23;
        tick();
        we = 1'b0;
        expect_val("waw_cleared", 32'h0);
        #1; observe({16'h0, busy_vec});

        // flush with simultaneous accepted issue and writeback
        iss_valid = 1'b1; iss_wr = 1'b1; iss_dst = 4'd1;
        tick(); iss_dst = 4'd6;
        tick(); iss_dst = 4'd9;
        tick();
        iss_dst = 4'd8; flush = 1'b1; we = 1'b1; wr_addr = 4'd10; wr_data = 32'h33;
        expect_val("pre_flush_busy", 32'h0242); expect_val("flush_issue_stall", 32'h0);
        #1; observe({16'h0, busy_vec}); observe({31'h0, stall});
        tick();
        flush = 1'b0; we = 1'b0; iss_valid = 1'b0; iss_wr = 1'b0;
        rd_addr1 = 4'd7; rd_addr2 = 4'd10;
        expect_val("flush_busy", 32'h0); expect_val("flush_r7", 32'h12345678);
        expect_val("flush_wb_r10", 32'h33);
        #1; observe({16'h0, busy_vec}); observe(reg1_data); observe(reg2_data);
        rd_addr1 = 4'd5; rd_addr2 = 4'd3;
        expect_val("flush_r5", 32'hA5A5A5A5); expect_val("flush_r3", 32'hDEADBEEF);
        #1; observe(reg1_data); observe(reg2_data);

        // asynchronous reset between edges
        iss_valid = 1'b1; iss_wr = 1'b1; iss_dst = 4'd1;
        tick(); iss_dst = 4'd11;
        tick();
        iss_wr = 1'b0; iss_use1 = 1'b1; rd_addr1 = 4'd1; rd_addr2 = 4'd7;
        expect_val("pre_rst_busy", 32'h0802); expect_val("pre_rst_stall", 32'h1);
        #1; observe({16'h0, busy_vec}); observe({31'h0, stall});
        #1; rst_n = 1'b0;
        expect_val("arst_busy", 32'h0); expect_val("arst_stall", 32'h0);
        expect_val("arst_r1", 32'h0); expect_val("arst_r7", 32'h0);
        #1; observe({16'h0, busy_vec}); observe({31'h0, stall});
        observe(reg1_data); observe(reg2_data);
        rd_addr1 = 4'd3; rd_addr2 = 4'd15;
        expect_val("arst_r3", 32'h0); expect_val("arst_pc", 32'h2008);
        #1; observe(reg1_data); observe(reg2_data);
        iss_valid = 1'b0; iss_use1 = 1'b0;
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with an integrated scoreboard for the pipelined core. It provides two combinational read ports and one clocked write port. Writes bypass to same-cycle reads, and reads of the top register return PC+8. A per-register busy bit tracks in-flight destination writes and raises a stall for RAW and WAW hazards at issue. It sits between decode/issue and writeback, and replaces the fixed 32-bit, 8-entry register file.

## Interface
- WIDTH, 32, data width in bits (≥ 8)
- NREGS, 16, number of architectural registers (power of two, ≥ 4); register NREGS-1 is the PC register
- AW, $clog2(NREGS), register address width (derived; not overridden)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr1, rd_addr2  in  AW  read addresses
- reg1_data, reg2_data  out  WIDTH  read data (combinational)
- pc  in  WIDTH  current PC of the instruction being read
- we  in  1  writeback enable
- wr_addr  in  AW  writeback register
- wr_data  in  WIDTH  writeback data
- iss_valid  in  1  an instruction is presented for issue
- iss_use1, iss_use2  in  1  instruction consumes rd_addr1 / rd_addr2
- iss_wr  in  1  instruction will write iss_dst
- iss_dst  in  AW  destination register of issuing instruction
- flush  in  1  pipeline flush: discard all outstanding writes
- stall  out  1  issue must hold (combinational)
- busy_vec  out  NREGS  current busy bits

## Operation
- Storage: rf[0..NREGS-1], WIDTH bits each.
- All registers, including r0, are writable. There is no hard-wired zero.
- Read port k:
  - If rd_addr == NREGS-1, the port returns pc + 8, truncated to WIDTH; stored contents are ignored.
  - Otherwise, if we && wr_addr == rd_addr, the port returns wr_data (write-through bypass).
  - Otherwise the port returns rf[rd_addr].
- Write: on a clk edge with we=1, rf[wr_addr] <= wr_data. Writes to NREGS-1 are stored but remain invisible on the read ports.
- Scoreboard:
  - busy_vec has one bit per register. Bit NREGS-1 is constantly 0.
  - Effective busy: eb[i] = busy_vec[i] && !(we && wr_addr == i). A register being written back this cycle counts as ready.
  - stall = iss_valid && ((iss_use1 && eb[rd_addr1]) || (iss_use2 && eb[rd_addr2]) || (iss_wr && eb[iss_dst])).
  - Issue is accepted when iss_valid && !stall.
- Busy bit update at each clk edge, in priority order:
  1. If flush=1, all bits clear. Flush overrides everything in the same cycle.
  2. Otherwise, if issue is accepted, iss_wr=1 and iss_dst != NREGS-1, busy_vec[iss_dst] sets.
  3. Otherwise, if we=1, busy_vec[wr_addr] clears.
  4. Set and clear of the same register in the same cycle leaves the bit set, because set wins.
- Writeback to a register that is not busy is legal: data is written and busy_vec is unchanged.
- flush does not alter rf contents. Writebacks in the flush cycle still update rf.

## Timing
- Read latency: 0 cycles (combinational from addresses, pc, we, wr_addr, wr_data and rf).
- Write latency: data is visible from rf in the cycle after the edge, and via bypass in the same cycle.
- Busy set/clear takes effect in busy_vec one edge after the issue/writeback cycle.
- stall has no registered delay. The issue stage samples stall in the same cycle it presents the instruction.
- Reset (rst_n=0, asynchronous, immediate):
  - All rf entries are 0 and busy_vec = 0.
  - reg*_data reads 0, except that the PC register reads pc+8.
  - stall = 0.
- Deassertion of rst_n is synchronised externally. The first functional edge is the first rising clk edge with rst_n=1.
- Reset mid-operation discards all pending busy state and all data. There is no partial update at the asserting edge.

## Test plan
- Reset and basic write/read:
  - Assert rst_n=0, then release.
  - Write r3=0xDEADBEEF and r7=0x12345678 on consecutive edges.
  - Required: after reset, r0..r14 read 0 and r15 with pc=0x100 reads 0x108.
  - Required: after the writes, rd_addr1=3 returns 0xDEADBEEF and rd_addr2=7 returns 0x12345678.
- Bypass and PC register:
  - Apply we=1, wr_addr=5, wr_data=0xA5A5A5A5 with rd_addr1=5 in the same cycle.
  - Separately write r15=0xFFFF with pc=0x2000.
  - Required: reg1_data is 0xA5A5A5A5 before the edge.
  - Required: reading r15 returns 0x2008, and busy_vec[15] stays 0.
- RAW hazard:
  - Issue with iss_wr=1, iss_dst=4.
  - Next cycle, issue with iss_use1=1, rd_addr1=4.
  - Write back r4=0x55 two cycles later.
  - Required: busy_vec=0x0010 after the first issue.
  - Required: stall=1 until the writeback cycle, and stall=0 in that cycle with reg1_data=0x55.
- WAW and simultaneous set/clear:
  - With r2 busy, issue a new writer of r2. Required: stall=1.
  - In the writeback cycle of r2, issue another writer of r2. Required: stall=0, and busy_vec[2] remains 1 after the edge.
- Flush and async reset mid-operation:
  - Set r1, r6 and r9 busy, then pulse flush together with an accepted issue to r8.
  - Required: busy_vec=0 after the edge and rf is unchanged.
  - Set busy bits again, then drop rst_n between clock edges.
  - Required: busy_vec=0 and all data=0 immediately, without waiting for a clock edge.
